// File: rtl/dmem_responder_if.sv
// dmem_responder_if: pipeline-side request/response bundle of the data-memory responder.
// The master side is the EX/MEM stage; the slave side is the responder.
interface dmem_responder_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;

  modport master (output MemRead_i, MemWrite_i, addr_i, data_i, input data_o, stall_o);
  modport slave  (input MemRead_i, MemWrite_i, addr_i, data_i, output data_o, stall_o);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory that freezes the pipeline for LATENCY cycles per access.
// Defining DMEM_RESP_PERF_EN adds a saturating stall-cycle counter on stall_cnt_o.
module dmem_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus
`ifdef DMEM_RESP_PERF_EN
  ,
  output logic [31:0]     stall_cnt_o
`endif
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_wr_q, op_wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             req_c;
  logic             wr_c;
  logic [IDX_W-1:0] in_idx_c;
  logic             stall_c;
  logic             acc_go_c;
  logic             acc_wr_c;
  logic [IDX_W-1:0] acc_idx_c;
  logic [31:0]      acc_wdata_c;
  logic             mem_we_c;
  logic             unused_addr_bits;

  // A simultaneous read+write request is treated as a write only.
  assign req_c            = bus.MemRead_i | bus.MemWrite_i;
  assign wr_c             = bus.MemWrite_i;
  assign in_idx_c         = bus.addr_i[IDX_W+1:2];
  assign unused_addr_bits = ^{bus.addr_i[31:IDX_W+2], bus.addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_c) state_d = (LATENCY == 1) ? DONE : BUSY;
      BUSY:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath; with LATENCY==1 the access uses the live inputs at the IDLE edge.
  always_comb begin
    stall_c     = 1'b0;
    acc_go_c    = 1'b0;
    acc_wr_c    = op_wr_q;
    acc_idx_c   = idx_q;
    acc_wdata_c = wdata_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          stall_c = 1'b1;
          op_wr_d = wr_c;
          idx_d   = in_idx_c;
          wdata_d = bus.data_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            acc_go_c    = 1'b1;
            acc_wr_c    = wr_c;
            acc_idx_c   = in_idx_c;
            acc_wdata_c = bus.data_i;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) acc_go_c = 1'b1;
      end
      default: ;
    endcase
    // Reset aborts any access in flight and drops the stall immediately.
    if (rst_i) begin
      stall_c  = 1'b0;
      acc_go_c = 1'b0;
    end
    mem_we_c = acc_go_c & acc_wr_c;
    data_d   = (acc_go_c & ~acc_wr_c) ? mem[acc_idx_c] : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) mem[acc_idx_c] <= acc_wdata_c;
  end

  assign bus.data_o  = data_q;
  assign bus.stall_o = stall_c;

`ifdef DMEM_RESP_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: checks a LATENCY=4 and a LATENCY=1 responder against an array-based memory model.
// Directed scenarios first, then randomized request streams with mixed idle and back-to-back spacing.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus4();
  dmem_responder_if bus1();

`ifdef DMEM_RESP_PERF_EN
  logic [31:0] stall_cnt4, stall_cnt1;
`endif

  dmem_responder #(.LATENCY(4), .DEPTH_WORDS(256)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4.slave)
`ifdef DMEM_RESP_PERF_EN
    , .stall_cnt_o(stall_cnt4)
`endif
  );

  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1.slave)
`ifdef DMEM_RESP_PERF_EN
    , .stall_cnt_o(stall_cnt1)
`endif
  );

  // Reference model: index 0 is the LATENCY=4 instance, index 1 the LATENCY=1 instance.
  logic [31:0] mdl_mem   [2][256];
  bit          mdl_valid [2][256];
  logic [31:0] mdl_dout  [2];

  function automatic int lat(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  function automatic logic get_stall(input int sel);
    return (sel == 0) ? bus4.stall_o : bus1.stall_o;
  endfunction

  function automatic logic [31:0] get_dout(input int sel);
    return (sel == 0) ? bus4.data_o : bus1.data_o;
  endfunction

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus4.MemRead_i = rd; bus4.MemWrite_i = wr; bus4.addr_i = a; bus4.data_i = d;
    end else begin
      bus1.MemRead_i = rd; bus1.MemWrite_i = wr; bus1.addr_i = a; bus1.data_i = d;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic model_req(input int sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[9:2]);
    if (wr) begin
      mdl_mem[sel][idx]   = d;
      mdl_valid[sel][idx] = 1'b1;
    end else if (rd) begin
      mdl_dout[sel] = mdl_mem[sel][idx];
    end
  endtask

  // Presents a request and holds it; returns cycles waited before stall, stall length and data_o in DONE.
  task automatic do_req(input int sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int gap, output int nstall, output logic [31:0] dout);
    @(negedge clk);
    drive(sel, rd, wr, a, d);
    #1;
    gap = 0;
    while (!get_stall(sel) && gap < 8) begin
      @(posedge clk); #1; gap++;
    end
    nstall = 0;
    while (get_stall(sel) && nstall < 40) begin
      nstall++;
      @(posedge clk); #1;
    end
    dout = get_dout(sel);
    model_req(sel, rd, wr, a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 1'b1, 32'h10, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus4.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall4 got=%b exp=0", bus4.stall_o); end
    checks++; if (bus1.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall1 got=%b exp=0", bus1.stall_o); end
    checks++; if (bus4.data_o !== 32'h0) begin errors++; $display("FAIL rst_dout4 got=%h exp=0", bus4.data_o); end
    checks++; if (bus1.data_o !== 32'h0) begin errors++; $display("FAIL rst_dout1 got=%h exp=0", bus1.data_o); end
    idle();
    rst = 1'b0;
    mdl_dout[0] = 32'h0;
    mdl_dout[1] = 32'h0;
    @(posedge clk);
  endtask

  task automatic test_write_read();
    int g, n; logic [31:0] dv;
    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, g, n, dv);
    checks++; if (n !== 4) begin errors++; $display("FAIL wr_stall got=%0d exp=4", n); end
    checks++; if (g !== 0) begin errors++; $display("FAIL wr_gap got=%0d exp=0", g); end
    checks++; if (dv !== 32'h0) begin errors++; $display("FAIL wr_dout got=%h exp=0", dv); end
    idle();
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, g, n, dv);
    checks++; if (n !== 4) begin errors++; $display("FAIL rd_stall got=%0d exp=4", n); end
    checks++; if (dv !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dout got=%h exp=deadbeef", dv); end
    idle();
  endtask

  task automatic test_latency1();
    int g, n; logic [31:0] dv;
    do_req(1, 1'b0, 1'b1, 32'h4, 32'h12345678, g, n, dv);
    idle();
    do_req(1, 1'b1, 1'b0, 32'h4, 32'h0, g, n, dv);
    checks++; if (n !== 1) begin errors++; $display("FAIL l1_stall got=%0d exp=1", n); end
    checks++; if (dv !== 32'h12345678) begin errors++; $display("FAIL l1_dout got=%h exp=12345678", dv); end
    idle();
  endtask

  task automatic test_rw_both();
    int g, n; logic [31:0] dv;
    do_req(0, 1'b0, 1'b1, 32'h40, 32'h1, g, n, dv);
    idle();
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, g, n, dv);
    checks++; if (dv !== 32'h1) begin errors++; $display("FAIL rw_pre got=%h exp=1", dv); end
    idle();
    do_req(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, g, n, dv);
    checks++; if (dv !== 32'h1) begin errors++; $display("FAIL rw_hold got=%h exp=1", dv); end
    idle();
    do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, g, n, dv);
    checks++; if (dv !== 32'hA5A5A5A5) begin errors++; $display("FAIL rw_read got=%h exp=a5a5a5a5", dv); end
    idle();
  endtask

  task automatic test_reset_mid();
    int g, n; logic [31:0] dv;
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h0, g, n, dv);
    idle();
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, g, n, dv);
    idle();
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h20, 32'hFFFF0000);
    #1;
    checks++; if (bus4.stall_o !== 1'b1) begin errors++; $display("FAIL mid_start got=%b exp=1", bus4.stall_o); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (bus4.stall_o !== 1'b0) begin errors++; $display("FAIL mid_rst_comb got=%b exp=0", bus4.stall_o); end
    @(posedge clk); #1;
    checks++; if (bus4.stall_o !== 1'b0) begin errors++; $display("FAIL mid_stall got=%b exp=0", bus4.stall_o); end
    checks++; if (bus4.data_o !== 32'h0) begin errors++; $display("FAIL mid_dout got=%h exp=0", bus4.data_o); end
    @(negedge clk);
    rst = 1'b0;
    mdl_dout[0] = 32'h0;
    mdl_dout[1] = 32'h0;
    @(posedge clk); #1;
    checks++; if (bus4.stall_o !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b exp=0", bus4.stall_o); end
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, g, n, dv);
    checks++; if (dv !== 32'h0) begin errors++; $display("FAIL mid_nowrite got=%h exp=0", dv); end
    idle();
  endtask

  task automatic test_alias();
    int g, n; logic [31:0] dv;
    do_req(0, 1'b0, 1'b1, 32'h400, 32'h55, g, n, dv);
    idle();
    do_req(0, 1'b1, 1'b0, 32'h000, 32'h0, g, n, dv);
    checks++; if (dv !== 32'h55) begin errors++; $display("FAIL alias0 got=%h exp=55", dv); end
    do_req(0, 1'b1, 1'b0, 32'h003, 32'h0, g, n, dv);
    checks++; if (dv !== 32'h55) begin errors++; $display("FAIL alias3 got=%h exp=55", dv); end
    checks++; if (g !== 1) begin errors++; $display("FAIL b2b_gap got=%0d exp=1", g); end
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_stall got=%0d exp=4", n); end
    idle();
  endtask

  task automatic test_random();
    int g, n, idx, op, eg;
    bit rd, wr, b2b;
    logic [31:0] a, d, dv;
    for (int sel = 0; sel < 2; sel++) begin
      idle();
      for (int k = 0; k < 30; k++) begin
        idx = $urandom_range(0, 15);
        a   = ($urandom & 32'hFFFF_FC03) | (32'(idx) << 2);
        d   = $urandom;
        op  = $urandom_range(0, 3);
        rd  = (op != 1);
        wr  = (op == 1) || (op == 2) || !mdl_valid[sel][idx];
        b2b = (k != 0) && ($urandom_range(0, 1) == 1);
        if (!b2b && k != 0) idle();
        eg = b2b ? 1 : 0;
        do_req(sel, rd, wr, a, d, g, n, dv);
        checks++; if (n !== lat(sel)) begin errors++; $display("FAIL rnd_stall sel=%0d k=%0d got=%0d exp=%0d", sel, k, n, lat(sel)); end
        checks++; if (g !== eg) begin errors++; $display("FAIL rnd_gap sel=%0d k=%0d got=%0d exp=%0d", sel, k, g, eg); end
        checks++; if (dv !== mdl_dout[sel]) begin errors++; $display("FAIL rnd_dout sel=%0d k=%0d got=%h exp=%h", sel, k, dv, mdl_dout[sel]); end
      end
      idle();
    end
  endtask

`ifdef DMEM_RESP_PERF_EN
  task automatic test_perf();
    int g, n; logic [31:0] dv;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_dout[0] = 32'h0;
    mdl_dout[1] = 32'h0;
    #1;
    checks++; if (stall_cnt4 !== 32'd0) begin errors++; $display("FAIL perf_clr got=%0d exp=0", stall_cnt4); end
    for (int k = 0; k < 3; k++) begin
      do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, g, n, dv);
      idle();
    end
    checks++; if (stall_cnt4 !== 32'd12) begin errors++; $display("FAIL perf_cnt got=%0d exp=12", stall_cnt4); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (stall_cnt4 !== 32'd0) begin errors++; $display("FAIL perf_rst got=%0d exp=0", stall_cnt4); end
    @(negedge clk);
    rst = 1'b0;
    mdl_dout[0] = 32'h0;
    mdl_dout[1] = 32'h0;
  endtask
`endif

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) mdl_valid[s][i] = 1'b0;
      mdl_dout[s] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_latency1();
    test_rw_both();
    test_reset_mid();
    test_alias();
    test_random();
`ifdef DMEM_RESP_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
